// File: rtl/roi_readout_ctrl.sv
// Post-frame sequencer: walks the connected-components table, divides the x/y
// sums by area with a shared bit-serial divider and streams one centroid per object.
module roi_readout_ctrl #(
  parameter int LOC_W  = 16,
  parameter int LBL_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LBL_W-1:0] num_labels,
  output logic [LBL_W-1:0] obj_id,
  input  logic [LOC_W-1:0] obj_area,
  input  logic [LOC_W-1:0] obj_x,
  input  logic [LOC_W-1:0] obj_y,
  output logic             cent_valid,
  input  logic             cent_ready,
  output logic [LBL_W-1:0] cent_id,
  output logic [LOC_W-1:0] cent_x,
  output logic [LOC_W-1:0] cent_y,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W  = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam int STEP_W = $clog2(LOC_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LATCH, S_DIV, S_OUT, S_NEXT, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [LBL_W-1:0]   num_labels_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [STEP_W-1:0]  step;
  logic [LOC_W-1:0]   rem_x, quo_x, rem_y, quo_y, den;
  logic [2*LOC_W-1:0] dx_nxt, dy_nxt;
  logic               last_step;

  // One restoring step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits. The quotient register doubles as
  // the dividend shift register, so after LOC_W steps it holds the floor.
  function automatic logic [2*LOC_W-1:0] div_step(
    input logic [LOC_W-1:0] rem,
    input logic [LOC_W-1:0] quo,
    input logic [LOC_W-1:0] dvs
  );
    logic [LOC_W:0]   trial;
    logic [LOC_W-1:0] q;
    trial = {rem, quo[LOC_W-1]};
    q     = {quo[LOC_W-2:0], 1'b0};
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      q[0]  = 1'b1;
    end
    return {trial[LOC_W-1:0], q};
  endfunction

  always_comb begin
    dx_nxt    = div_step(rem_x, quo_x, den);
    dy_nxt    = div_step(rem_y, quo_y, den);
    last_step = (step == STEP_W'(LOC_W - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_labels != '0) ? S_WAIT : S_DONE;
      S_WAIT:  if (wait_cnt == CNT_W'(1)) state_nxt = S_LATCH;
      S_LATCH: state_nxt = (obj_area == '0) ? S_NEXT : S_DIV;
      S_DIV:   if (last_step) state_nxt = S_OUT;
      S_OUT:   if (cent_ready) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (obj_id == num_labels_q) ? S_DONE : S_WAIT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cent_valid = (state == S_OUT);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
  end

  // Sequencing registers and the held output beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      obj_id       <= LBL_W'(1);
      num_labels_q <= '0;
      wait_cnt     <= '0;
      step         <= '0;
      cent_id      <= '0;
      cent_x       <= '0;
      cent_y       <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && num_labels != '0) begin
          num_labels_q <= num_labels;
          obj_id       <= LBL_W'(1);
          wait_cnt     <= CNT_W'(RD_LAT);
        end
        S_WAIT:  wait_cnt <= wait_cnt - CNT_W'(1);
        S_LATCH: step     <= '0;
        S_DIV: begin
          step <= step + STEP_W'(1);
          if (last_step) begin
            cent_id <= obj_id;
            cent_x  <= dx_nxt[LOC_W-1:0];
            cent_y  <= dy_nxt[LOC_W-1:0];
          end
        end
        S_NEXT: if (obj_id != num_labels_q) begin
          obj_id   <= obj_id + LBL_W'(1);
          wait_cnt <= CNT_W'(RD_LAT);
        end
        default: ;
      endcase
    end
  end

  // Divider datapath: loaded in LATCH, iterated in DIV
  always_ff @(posedge clk) begin
    if (state == S_LATCH) begin
      rem_x <= '0;
      rem_y <= '0;
      quo_x <= obj_x;
      quo_y <= obj_y;
      den   <= obj_area;
    end else if (state == S_DIV) begin
      {rem_x, quo_x} <= dx_nxt;
      {rem_y, quo_y} <= dy_nxt;
    end
  end

endmodule

// File: tb/tb_roi_readout_ctrl.sv
// Scoreboard bench for roi_readout_ctrl: directed scans against a registered
// data-table model, with a negedge monitor popping expected centroid beats.
module tb_roi_readout_ctrl;
  localparam int LOC_W = 16, LBL_W = 8, RD_LAT = 1;

  logic             clk = 1'b0, reset_n = 1'b0, start = 1'b0, cent_ready = 1'b1;
  logic [LBL_W-1:0] num_labels = '0, obj_id, cent_id;
  logic [LOC_W-1:0] obj_area = '0, obj_x = '0, obj_y = '0, cent_x, cent_y;
  logic             cent_valid, busy, done;

  roi_readout_ctrl #(.LOC_W(LOC_W), .LBL_W(LBL_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_labels(num_labels),
    .obj_id(obj_id), .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y),
    .cent_valid(cent_valid), .cent_ready(cent_ready), .cent_id(cent_id),
    .cent_x(cent_x), .cent_y(cent_y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [LOC_W-1:0] mem_a [256];
  logic [LOC_W-1:0] mem_x [256];
  logic [LOC_W-1:0] mem_y [256];

  // Data table with one cycle of read latency
  initial forever begin
    @(posedge clk);
    obj_area <= mem_a[obj_id];
    obj_x    <= mem_x[obj_id];
    obj_y    <= mem_y[obj_id];
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  typedef logic [LBL_W+2*LOC_W-1:0] beat_t;
  beat_t sb[$];
  int    n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  int    beat_cnt = 0, done_cnt = 0, first_valid_cyc = -1, hs_cyc = 0, done_cyc = 0;
  logic  visited [256];
  logic  stalled = 1'b0, done_prev = 1'b0, busy_after_done = 1'b1;
  beat_t held;

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      stalled   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(cent_valid), 64'd1);
        chk("stall_beat", 64'({cent_id, cent_x, cent_y}), 64'(held));
      end
      stalled = 1'b0;
      if (cent_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (cent_valid && !cent_ready) begin
        stalled = 1'b1;
        held    = {cent_id, cent_x, cent_y};
      end
      if (cent_valid && cent_ready) begin
        beat_cnt++;
        hs_cyc = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got id=%0d x=%0h y=%0h, none required", cent_id, cent_x, cent_y);
        end else begin
          chk("beat", 64'({cent_id, cent_x, cent_y}), 64'(sb.pop_front()));
        end
      end
      if (done_prev) busy_after_done = busy;
      done_prev = done;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) visited[obj_id] = 1'b1;
    end
  end

  task automatic set_obj(input int id, input int a, input int x, input int y);
    mem_a[id] = LOC_W'(a);
    mem_x[id] = LOC_W'(x);
    mem_y[id] = LOC_W'(y);
  endtask

  task automatic push(input int id, input int x, input int y);
    sb.push_back({LBL_W'(id), LOC_W'(x), LOC_W'(y)});
  endtask

  task automatic pulse_start(input int nl, output int s_cyc);
    @(posedge clk); #1;
    num_labels = LBL_W'(nl);
    start = 1'b1;
    first_valid_cyc = -1;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int prev, i;
    prev = done_cnt;
    for (i = 0; i < budget && done_cnt == prev; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_done_seen"}, 64'(done_cnt - prev), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input string nm, input int target, input int budget);
    int i;
    for (i = 0; i < budget && beat_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_beat_timeout"}, 64'(beat_cnt >= target), 64'd1);
  endtask

  int s, b0, i;

  initial begin
    for (int k = 0; k < 256; k++) begin
      set_obj(k, 1, 0, 0);
      visited[k] = 1'b0;
    end

    // Reset state
    #12;
    chk("rst_obj_id", 64'(obj_id), 64'd1);
    chk("rst_valid", 64'(cent_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cent", 64'({cent_id, cent_x, cent_y}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Empty frame: done, no beat, obj_id stays 1
    b0 = beat_cnt;
    pulse_start(0, s);
    wait_done("empty", 10);
    chk("empty_beats", 64'(beat_cnt - b0), 64'd0);
    chk("empty_obj_id", 64'(obj_id), 64'd1);

    // Single object, latency and done timing
    set_obj(1, 4, 40, 12);
    push(1, 10, 3);
    pulse_start(1, s);
    wait_done("single", 60);
    chk("single_latency", 64'(first_valid_cyc - s), 64'd18);
    chk("single_done_gap", 64'(done_cyc - hs_cyc), 64'd2);
    chk("single_busy_fall", 64'(busy_after_done), 64'd0);
    chk("single_sb_empty", 64'(sb.size()), 64'd0);

    // Three objects, beat 2 stalled for 5 cycles
    set_obj(1, 2, 7, 1);
    set_obj(2, 3, 9, 30);
    set_obj(3, 5, 50, 24);
    push(1, 3, 0); push(2, 3, 10); push(3, 10, 4);
    b0 = beat_cnt;
    pulse_start(3, s);
    wait_beats("bp1", b0 + 1, 60);
    cent_ready = 1'b0;
    for (i = 0; i < 60 && !cent_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", 64'(cent_valid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    cent_ready = 1'b1;
    wait_done("bp", 80);
    chk("bp_beats", 64'(beat_cnt - b0), 64'd3);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Zero-area object skipped but still visited
    set_obj(1, 4, 8, 4);
    set_obj(2, 0, 5, 5);
    set_obj(3, 6, 60, 13);
    push(1, 2, 1); push(3, 10, 2);
    for (int k = 0; k < 256; k++) visited[k] = 1'b0;
    b0 = beat_cnt;
    pulse_start(3, s);
    wait_done("zero", 100);
    chk("zero_beats", 64'(beat_cnt - b0), 64'd2);
    chk("zero_visit", 64'({visited[1], visited[2], visited[3]}), 64'b111);
    chk("zero_sb_empty", 64'(sb.size()), 64'd0);

    // Start re-pulsed mid-scan is ignored
    set_obj(1, 2, 8, 6);
    set_obj(2, 4, 20, 9);
    push(1, 4, 3); push(2, 5, 2);
    b0 = beat_cnt;
    pulse_start(2, s);
    repeat (5) @(posedge clk);
    pulse_start(5, s);
    num_labels = '0;
    wait_done("restart", 80);
    repeat (30) @(posedge clk);
    #1;
    chk("restart_beats", 64'(beat_cnt - b0), 64'd2);
    chk("restart_idle", 64'(busy), 64'd0);
    chk("restart_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset during DIV of id 2
    set_obj(1, 2, 8, 6);
    set_obj(2, 4, 20, 9);
    set_obj(3, 1, 1, 1);
    push(1, 4, 3); push(2, 5, 2); push(3, 1, 1);
    b0 = beat_cnt;
    pulse_start(3, s);
    wait_beats("rst1", b0 + 1, 60);
    repeat (8) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", 64'(cent_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_obj_id", 64'(obj_id), 64'd1);
    chk("mid_rst_cent", 64'({cent_id, cent_x, cent_y}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    push(1, 4, 3);
    pulse_start(1, s);
    wait_done("post_rst", 60);
    chk("post_rst_latency", 64'(first_valid_cyc - s), 64'd18);
    chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

    // Division boundaries
    set_obj(1, 1, 16'hFFFF, 7);
    set_obj(2, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    push(1, 16'hFFFF, 7); push(2, 1, 0);
    pulse_start(2, s);
    wait_done("bound", 80);
    chk("bound_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
